// File: rtl/seq_stage_ctrl_if.sv
// Control/status bundle between the SEQ stage sequencer and its environment.
// master = the sequencer, slave = the datapath/memory side driving its inputs.
interface seq_stage_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             stop;
    logic [3:0]       icode;
    logic             instr_valid;
    logic             imem_error;
    logic             mem_ready;
    logic             dmem_error;
    logic             fetch_en;
    logic             decode_en;
    logic             execute_en;
    logic             memory_en;
    logic             wb_en;
    logic             pc_en;
    logic             mem_req;
    logic [1:0]       stat;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  start, stop, icode, instr_valid, imem_error, mem_ready, dmem_error,
        output fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en, mem_req,
               stat, busy, halted, cycle_cnt, instr_cnt
    );

    modport slave (
        output start, stop, icode, instr_valid, imem_error, mem_ready, dmem_error,
        input  fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en, mem_req,
               stat, busy, halted, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle Y86-64 SEQ sequencer: one stage enable per cycle, data memory handshake
// with timeout, sticky HALT with status code, busy-cycle and retired-instruction counters.
module seq_stage_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    seq_stage_ctrl_if.master    bus
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StPcupdate,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        stat_q, stat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cycle_cnt_q, instr_cnt_q;
    logic              retire;
    logic              mem_icode;
    logic              busy;

    assign mem_icode = bus.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    assign busy      = (state_q != StIdle) && (state_q != StHalt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            stat_q      <= STAT_AOK;
            wait_q      <= '0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            wait_q  <= wait_d;
            if (busy) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (retire) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        wait_d  = '0;
        retire  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) state_d = StFetch;
            end
            StFetch: begin
                if (bus.imem_error) begin
                    state_d = StHalt;
                    stat_d  = STAT_ADR;
                end else if (!bus.instr_valid || bus.icode > 4'hB) begin
                    state_d = StHalt;
                    stat_d  = STAT_INS;
                end else if (bus.icode == 4'h0) begin
                    state_d = StHalt;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = StDecode;
                end
            end
            StDecode:  state_d = StExecute;
            StExecute: state_d = StMemory;
            StMemory: begin
                if (!mem_icode) begin
                    state_d = StWriteback;
                end else if (bus.mem_ready) begin
                    // A data fault skips writeback, so the instruction never retires.
                    if (bus.dmem_error) begin
                        state_d = StHalt;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = StWriteback;
                    end
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = StHalt;
                    stat_d  = STAT_ADR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StWriteback: state_d = StPcupdate;
            StPcupdate: begin
                retire  = 1'b1;
                state_d = bus.stop ? StIdle : StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.fetch_en   = 1'b0;
        bus.decode_en  = 1'b0;
        bus.execute_en = 1'b0;
        bus.memory_en  = 1'b0;
        bus.wb_en      = 1'b0;
        bus.pc_en      = 1'b0;
        bus.mem_req    = 1'b0;
        case (state_q)
            StFetch:     bus.fetch_en   = 1'b1;
            StDecode:    bus.decode_en  = 1'b1;
            StExecute:   bus.execute_en = 1'b1;
            StMemory: begin
                bus.memory_en = 1'b1;
                bus.mem_req   = mem_icode;
            end
            StWriteback: bus.wb_en      = 1'b1;
            StPcupdate:  bus.pc_en      = 1'b1;
            default: ;
        endcase
    end

    assign bus.stat      = stat_q;
    assign bus.busy      = busy;
    assign bus.halted    = (state_q == StHalt);
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Bench for seq_stage_ctrl: per-cycle expected stage vectors go through a scoreboard
// queue, status and counters are checked directly at instruction boundaries.
module tb_seq_stage_ctrl;

    localparam int unsigned CNT_W = 32;

    // {fetch, decode, execute, memory, wb, pc, mem_req, busy, halted}
    localparam logic [8:0] V_IDLE = 9'b000000_000;
    localparam logic [8:0] V_F    = 9'b100000_010;
    localparam logic [8:0] V_D    = 9'b010000_010;
    localparam logic [8:0] V_E    = 9'b001000_010;
    localparam logic [8:0] V_M    = 9'b000100_010;
    localparam logic [8:0] V_MR   = 9'b000100_110;
    localparam logic [8:0] V_W    = 9'b000010_010;
    localparam logic [8:0] V_P    = 9'b000001_010;
    localparam logic [8:0] V_H    = 9'b000000_001;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [8:0] exp_q[$];

    seq_stage_ctrl_if #(.CNT_W(CNT_W)) bus ();

    seq_stage_ctrl #(
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {bus.fetch_en, bus.decode_en, bus.execute_en, bus.memory_en, bus.wb_en,
                bus.pc_en, bus.mem_req, bus.busy, bus.halted};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check_eq("stage_vec", 64'(outs()), 64'(e));
        end
    end

    // Advance to just after the next rising edge and record what that cycle should show.
    task automatic cyc(input logic [8:0] e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic check_status(input string tag, input logic [1:0] st,
                                input int unsigned cyc_n, input int unsigned ins_n);
        check_eq({tag, "_stat"}, 64'(bus.stat), 64'(st));
        check_eq({tag, "_cycle_cnt"}, 64'(bus.cycle_cnt), 64'(cyc_n));
        check_eq({tag, "_instr_cnt"}, 64'(bus.instr_cnt), 64'(ins_n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.dmem_error = 1'b0;
        bus.imem_error = 1'b0;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    logic [3:0] f_icode [5] = '{4'h0, 4'hC, 4'hC, 4'h3, 4'hF};
    logic       f_valid [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       f_imerr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] f_stat  [5] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd3};

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.icode       = 4'h0;
        bus.instr_valid = 1'b1;
        bus.imem_error  = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.dmem_error  = 1'b0;
        #1 reset = 1'b1;
        #2;
        check_eq("rst_vec", 64'(outs()), 64'(V_IDLE));
        check_status("rst", 2'd0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // irmovq, then free-running into mrmovq with mem_ready on the 3rd MEMORY cycle
        bus.start = 1'b1;
        bus.icode = 4'h3;
        cyc(V_F); bus.start = 1'b0;
        cyc(V_D); cyc(V_E); cyc(V_M); cyc(V_W); cyc(V_P);
        cyc(V_F);
        check_status("irmovq", 2'd0, 6, 1);
        bus.icode = 4'h5;
        cyc(V_D); cyc(V_E);
        cyc(V_MR); cyc(V_MR);
        cyc(V_MR); bus.mem_ready = 1'b1;
        cyc(V_W);  bus.mem_ready = 1'b0;
        cyc(V_P);  bus.stop = 1'b1;
        cyc(V_IDLE); bus.stop = 1'b0;
        check_status("mrmovq", 2'd0, 14, 2);
        cyc(V_IDLE);

        // call: mem_ready on the last allowed cycle beats the timeout
        bus.start = 1'b1;
        bus.icode = 4'h8;
        cyc(V_F); bus.start = 1'b0;
        cyc(V_D); cyc(V_E);
        cyc(V_MR); cyc(V_MR); cyc(V_MR);
        cyc(V_MR); bus.mem_ready = 1'b1;
        cyc(V_W);  bus.mem_ready = 1'b0;
        cyc(V_P);  bus.stop = 1'b1;
        cyc(V_IDLE); bus.stop = 1'b0;
        check_status("call_edge", 2'd0, 23, 3);

        // popq with a data fault: no writeback, not retired, sticky HALT
        bus.start = 1'b1;
        bus.icode = 4'hB;
        cyc(V_F); bus.start = 1'b0;
        cyc(V_D); cyc(V_E);
        cyc(V_MR); bus.mem_ready = 1'b1; bus.dmem_error = 1'b1;
        cyc(V_H);  bus.mem_ready = 1'b0; bus.dmem_error = 1'b0;
        check_status("dmem_err", 2'd2, 27, 3);
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc(V_H); bus.start = 1'b0; bus.stop = 1'b0;
        cyc(V_H);
        check_status("halt_sticky", 2'd2, 27, 3);

        // pushq timing out with mem_ready held low
        do_reset();
        bus.start = 1'b1;
        bus.icode = 4'hA;
        cyc(V_F); bus.start = 1'b0;
        cyc(V_D); cyc(V_E);
        cyc(V_MR); cyc(V_MR); cyc(V_MR); cyc(V_MR);
        cyc(V_H);
        check_status("timeout", 2'd2, 7, 0);
        bus.start = 1'b1;
        cyc(V_H); bus.start = 1'b0;
        cyc(V_H);

        // FETCH faults
        for (int i = 0; i < 5; i++) begin
            do_reset();
            bus.start       = 1'b1;
            bus.icode       = f_icode[i];
            bus.instr_valid = f_valid[i];
            bus.imem_error  = f_imerr[i];
            cyc(V_F); bus.start = 1'b0;
            cyc(V_H);
            check_status($sformatf("fetch_fault%0d", i), f_stat[i], 1, 0);
        end

        // Reset in the middle of a pending memory access
        do_reset();
        bus.start = 1'b1;
        bus.icode = 4'h4;
        cyc(V_F); bus.start = 1'b0;
        cyc(V_D); cyc(V_E); cyc(V_MR); cyc(V_MR);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midmem_vec", 64'(outs()), 64'(V_IDLE));
        check_status("midmem_rst", 2'd0, 0, 0);
        #2 reset = 1'b0;
        bus.start = 1'b1;
        bus.icode = 4'h6;
        cyc(V_F); bus.start = 1'b0;
        cyc(V_D); cyc(V_E); cyc(V_M); cyc(V_W);
        cyc(V_P); bus.stop = 1'b1;
        cyc(V_IDLE); bus.stop = 1'b0;
        check_status("restart", 2'd0, 6, 1);

        @(negedge clk);
        #1;
        check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
